// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Queue entries pair each instruction word with the PC it was fetched from.
package fetch_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int PC_INC       = 4;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: control, instruction-memory request/response and
// decode handshake. master is the fetch unit, slave is its environment.
interface fetch_queue_if #(
   parameter int XLEN = 32
);

   logic            run;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [XLEN-1:0] imem_rdata_i;

   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] instr_o;

   modport master (
      input  run,
      input  redirect_i,
      input  redirect_pc_i,
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i,
      output valid_o,
      input  ready_i,
      output pc_o,
      output instr_o
   );

   modport slave (
      output run,
      output redirect_i,
      output redirect_pc_i,
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i,
      input  valid_o,
      output ready_i,
      input  pc_o,
      input  instr_o
   );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Generic synchronous FIFO with flush; used for the prefetch queue and
// for the PC tags of in-flight memory requests.
module sync_fifo #(
   parameter type T     = logic [31:0],
   parameter int  DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  T              din,
   input  logic          pop,
   input  logic          flush,
   output T              dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   T mem [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= nxt(wr_ptr);
         if (do_pop)  rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential prefetch into a DEPTH-entry
// queue, in-order memory responses, redirect flush with response dropping.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN            = XLEN_DEFAULT,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input logic         clk,
   input logic         reset,
   fetch_queue_if.master bus
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = ((CW > OW) ? CW : OW) + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] tag_pc;
   logic [CW-1:0]   count;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   drop_cnt;
   logic [SW-1:0]   credit;
   logic            q_full;
   logic            q_empty;
   logic            tag_full;
   logic            tag_empty;
   logic            req;
   logic            fire;
   logic            rsp;
   logic            drop;
   logic            push_q;
   logic            pop_q;
   logic            valid;
   entry_t          head;
   entry_t          rsp_entry;

   // Slots already promised to live in-flight requests count as used.
   assign credit = SW'(count) + SW'(outstanding) - SW'(drop_cnt);

   // reset is active low, so requests are held off while it is asserted.
   assign req = reset && bus.run && !bus.redirect_i && !tag_full
             && !q_full && (credit < SW'(DEPTH));

   assign fire      = req && bus.imem_gnt_i;
   assign rsp       = bus.imem_rvalid_i && !tag_empty;
   assign drop      = (drop_cnt != '0);
   assign push_q    = rsp && !drop && !bus.redirect_i;
   assign valid     = !q_empty && !bus.redirect_i;
   assign pop_q     = valid && bus.ready_i;
   assign rsp_entry = '{pc: tag_pc, instr: bus.imem_rdata_i};

   assign bus.imem_req_o  = req;
   assign bus.imem_addr_o = fetch_pc;
   assign bus.valid_o     = valid;
   assign bus.pc_o        = head.pc;
   assign bus.instr_o     = head.instr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else if (bus.redirect_i) begin
         fetch_pc <= bus.redirect_pc_i;
         drop_cnt <= outstanding - OW'(rsp);
      end else begin
         if (fire)         fetch_pc <= fetch_pc + XLEN'(PC_INC);
         if (rsp && drop)  drop_cnt <= drop_cnt - OW'(1);
      end
   end

   sync_fifo #(
      .T     (entry_t),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (reset),
      .push  (push_q),
      .din   (rsp_entry),
      .pop   (pop_q),
      .flush (bus.redirect_i),
      .dout  (head),
      .count (count),
      .full  (q_full),
      .empty (q_empty)
   );

   // Tags survive redirects so each response stays paired with its request.
   sync_fifo #(
      .T     (logic [XLEN-1:0]),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tags (
      .clk   (clk),
      .rst_n (reset),
      .push  (fire),
      .din   (fetch_pc),
      .pop   (rsp),
      .flush (1'b0),
      .dout  (tag_pc),
      .count (outstanding),
      .full  (tag_full),
      .empty (tag_empty)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push expected beats,
// a monitor models memory and checks grants and decode beats.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int XL = 32;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   fetch_queue_if #(.XLEN(XL)) bus ();

   fetch_queue #(
      .XLEN            (XL),
      .DEPTH           (4),
      .MAX_OUTSTANDING (2),
      .RESET_PC        (32'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int           checks    = 0;
   int           errors    = 0;
   int           cyc       = 0;
   int           grants    = 0;
   int           delivered = 0;
   int           first_gnt = -1;
   int           first_vld = -1;
   int           last_gnt  = -1;
   int           lat       = 1;
   logic [31:0]  exp_addr  = 32'h0;
   fetch_entry_t exp_q[$];
   pend_t        mem_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] p;
         p = base + 32'(4 * i);
         exp_q.push_back('{pc: p, instr: mem_word(p)});
      end
   endtask

   task automatic fetch_n(input int n);
      int start;
      int t;
      start   = grants;
      t       = 0;
      bus.run = 1'b1;
      while ((grants - start) < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      if ((grants - start) < n) begin
         checks++;
         errors++;
         $display("FAIL fetch_n_timeout: got %0d grants expected %0d",
                  grants - start, n);
      end
      bus.run = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats left expected 0",
                  exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pulse_redirect(input logic [31:0] a);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = a;
      exp_addr          = a;
      #2;
      chk("redirect_valid", {31'b0, bus.valid_o}, 32'd0);
      chk("redirect_req", {31'b0, bus.imem_req_o}, 32'd0);
      @(negedge clk);
      bus.redirect_i = 1'b0;
   endtask

   // Memory model and monitor: drive on the falling edge, sample just
   // before the rising edge.
   always begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
         mem_q.delete();
         bus.imem_rvalid_i = 1'b0;
         bus.imem_rdata_i  = '0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         bus.imem_rvalid_i = 1'b1;
         bus.imem_rdata_i  = mem_word(mem_q[0].addr);
      end else begin
         bus.imem_rvalid_i = 1'b0;
         bus.imem_rdata_i  = '0;
      end
      #4;
      if (reset) begin
         if (bus.imem_rvalid_i) void'(mem_q.pop_front());
         if (bus.imem_req_o && bus.imem_gnt_i) begin
            chk("imem_addr", bus.imem_addr_o, exp_addr);
            exp_addr = exp_addr + 32'd4;
            grants++;
            if (first_gnt < 0) first_gnt = cyc;
            last_gnt = cyc;
            mem_q.push_back('{addr: bus.imem_addr_o, due: cyc + lat});
         end
         if (bus.valid_o && bus.ready_i) begin
            delivered++;
            if (first_vld < 0) first_vld = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got pc %h expected none",
                        bus.pc_o);
            end else begin
               fetch_entry_t e;
               e = exp_q.pop_front();
               chk("beat_pc", bus.pc_o, e.pc);
               chk("beat_instr", bus.instr_o, e.instr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      int g0;
      bus.run           = 1'b1;
      bus.ready_i       = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      bus.imem_gnt_i    = 1'b1;

      // Reset state with run already high.
      repeat (3) @(negedge clk);
      #2;
      chk("rst_valid", {31'b0, bus.valid_o}, 32'd0);
      chk("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
      @(negedge clk);

      // Streaming from RESET_PC with zero-wait memory.
      reset       = 1'b1;
      bus.ready_i = 1'b1;
      lat         = 1;
      first_gnt   = -1;
      first_vld   = -1;
      push_exp(32'h0, 8);
      fetch_n(8);
      wait_drain();
      chk("first_valid_latency", 32'(first_vld - first_gnt), 32'd2);
      chk("stream_grant_span", 32'(last_gnt - first_gnt), 32'd7);

      // Queue fills to DEPTH with decode stalled.
      bus.ready_i = 1'b0;
      bus.run     = 1'b1;
      g0          = grants;
      repeat (10) @(negedge clk);
      #2;
      chk("full_grants", 32'(grants - g0), 32'd4);
      chk("full_req", {31'b0, bus.imem_req_o}, 32'd0);
      chk("full_valid", {31'b0, bus.valid_o}, 32'd1);
      chk("full_head_pc", bus.pc_o, 32'h20);
      bus.run = 1'b0;
      push_exp(32'h20, 8);
      @(negedge clk);
      bus.ready_i = 1'b1;
      d0          = delivered;
      repeat (4) @(negedge clk);
      chk("drain_4", 32'(delivered - d0), 32'd4);
      fetch_n(4);
      wait_drain();

      // Redirect with a filled queue and two requests in flight.
      bus.ready_i = 1'b0;
      lat         = 1;
      fetch_n(2);
      lat = 3;
      fetch_n(2);
      bus.run = 1'b1;
      push_exp(32'h100, 4);
      pulse_redirect(32'h100);
      lat         = 1;
      bus.ready_i = 1'b1;
      fetch_n(4);
      wait_drain();

      // Redirect coincident with a response and ready high.
      bus.ready_i = 1'b0;
      lat         = 1;
      fetch_n(1);
      @(negedge clk);
      lat = 2;
      fetch_n(2);
      push_exp(32'h200, 4);
      bus.ready_i = 1'b1;
      d0          = delivered;
      pulse_redirect(32'h200);
      chk("redirect_no_consume", 32'(delivered - d0), 32'd0);
      lat = 1;
      fetch_n(4);
      wait_drain();

      // PC wrap, with the request held while grant is low.
      bus.run = 1'b1;
      pulse_redirect(32'hFFFF_FFF8);
      bus.imem_gnt_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("hold_req", {31'b0, bus.imem_req_o}, 32'd1);
         chk("hold_addr", bus.imem_addr_o, 32'hFFFF_FFF8);
         @(negedge clk);
      end
      bus.imem_gnt_i = 1'b1;
      exp_q.push_back('{pc: 32'hFFFF_FFF8, instr: mem_word(32'hFFFF_FFF8)});
      exp_q.push_back('{pc: 32'hFFFF_FFFC, instr: mem_word(32'hFFFF_FFFC)});
      push_exp(32'h0, 2);
      fetch_n(4);
      wait_drain();

      // Asynchronous reset mid-stream with two requests outstanding.
      bus.ready_i = 1'b0;
      lat         = 1;
      fetch_n(2);
      repeat (2) @(negedge clk);
      lat = 3;
      fetch_n(2);
      bus.run = 1'b1;
      #2;
      chk("pre_reset_valid", {31'b0, bus.valid_o}, 32'd1);
      reset = 1'b0;
      mem_q.delete();
      #1;
      chk("reset_valid", {31'b0, bus.valid_o}, 32'd0);
      chk("reset_req", {31'b0, bus.imem_req_o}, 32'd0);
      repeat (2) @(negedge clk);
      exp_addr    = 32'h0;
      lat         = 1;
      bus.ready_i = 1'b1;
      push_exp(32'h0, 4);
      reset = 1'b1;
      fetch_n(4);
      wait_drain();
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
